// File: rtl/alu_issue_ctrl.sv
// Execute-stage controller for an external combinational ALU.
// It decodes RV32I ALU/branch ops, registers the result and redirects on taken branches.
module alu_issue_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_mode,
    input  logic [XLEN-1:0] alu_x,
    input  logic            alu_zero,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_data,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            illegal
);
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [3:0] M_ADD  = 4'b0000;
    localparam logic [3:0] M_SUB  = 4'b0001;
    localparam logic [3:0] M_AND  = 4'b0010;
    localparam logic [3:0] M_OR   = 4'b0011;
    localparam logic [3:0] M_XOR  = 4'b0100;
    localparam logic [3:0] M_SLL  = 4'b0101;
    localparam logic [3:0] M_SRL  = 4'b0110;
    localparam logic [3:0] M_SRA  = 4'b0111;
    localparam logic [3:0] M_LTU  = 4'b1000;
    localparam logic [3:0] M_GEU  = 4'b1001;
    localparam logic [3:0] M_NE   = 4'b1011;
    localparam logic [3:0] M_LT   = 4'b1100;
    localparam logic [3:0] M_GE   = 4'b1101;

    logic [6:0]  w_op;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_immi;
    logic [31:0] w_immu;
    logic [31:0] w_immb;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [3:0]  w_mode;
    logic        w_ill;
    logic        w_br;
    logic        w_slt;

    logic        r_ex_valid;
    logic        r_ex_br;
    logic        r_ex_slt;
    logic [4:0]  r_ex_rd;
    logic [31:0] r_ex_tgt;
    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;
    logic [3:0]  r_alu_mode;
    logic        r_out_valid;
    logic [4:0]  r_out_rd;
    logic [31:0] r_out_data;
    logic        r_redir_valid;
    logic [31:0] r_redir_pc;
    logic        r_ill;

    logic        w_out_free;
    logic        w_ex_adv;
    logic        w_ex_taken;
    logic        w_acc;
    logic [31:0] w_res;

    assign w_op   = in_instr[6:0];
    assign w_f3   = in_instr[14:12];
    assign w_f7   = in_instr[31:25];
    assign w_immi = {{20{in_instr[31]}}, in_instr[31:20]};
    assign w_immu = {in_instr[31:12], 12'b0};
    assign w_immb = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};

    always_comb begin
        w_a    = in_rs1;
        w_b    = in_rs2;
        w_mode = M_ADD;
        w_ill  = 1'b0;
        w_br   = 1'b0;
        w_slt  = 1'b0;
        unique case (w_op)
            OPC_OP: begin
                unique case ({w_f7, w_f3})
                    {7'h00, 3'b000}: w_mode = M_ADD;
                    {7'h20, 3'b000}: w_mode = M_SUB;
                    {7'h00, 3'b001}: begin w_mode = M_SLL; w_b = {27'b0, in_rs2[4:0]}; end
                    {7'h00, 3'b010}: begin w_mode = M_LT;  w_slt = 1'b1; end
                    {7'h00, 3'b011}: begin w_mode = M_LTU; w_slt = 1'b1; end
                    {7'h00, 3'b100}: w_mode = M_XOR;
                    {7'h00, 3'b101}: begin w_mode = M_SRL; w_b = {27'b0, in_rs2[4:0]}; end
                    {7'h20, 3'b101}: begin w_mode = M_SRA; w_b = {27'b0, in_rs2[4:0]}; end
                    {7'h00, 3'b110}: w_mode = M_OR;
                    {7'h00, 3'b111}: w_mode = M_AND;
                    default:         w_ill = 1'b1;
                endcase
            end
            OPC_IMM: begin
                w_b = w_immi;
                unique case (w_f3)
                    3'b000: w_mode = M_ADD;
                    3'b010: begin w_mode = M_LT;  w_slt = 1'b1; end
                    3'b011: begin w_mode = M_LTU; w_slt = 1'b1; end
                    3'b100: w_mode = M_XOR;
                    3'b110: w_mode = M_OR;
                    3'b111: w_mode = M_AND;
                    3'b001: begin
                        w_mode = M_SLL;
                        w_b    = {27'b0, in_instr[24:20]};
                        w_ill  = (w_f7 != 7'h00);
                    end
                    default: begin
                        w_mode = (w_f7 == 7'h20) ? M_SRA : M_SRL;
                        w_b    = {27'b0, in_instr[24:20]};
                        w_ill  = (w_f7 != 7'h00) && (w_f7 != 7'h20);
                    end
                endcase
            end
            OPC_BR: begin
                w_br = 1'b1;
                unique case (w_f3)
                    3'b000:  w_mode = M_SUB;
                    3'b001:  w_mode = M_NE;
                    3'b100:  w_mode = M_LT;
                    3'b101:  w_mode = M_GE;
                    3'b110:  w_mode = M_LTU;
                    3'b111:  w_mode = M_GEU;
                    default: w_ill = 1'b1;
                endcase
            end
            OPC_LUI: begin
                w_a = 32'b0;
                w_b = w_immu;
            end
            OPC_AUIPC: begin
                w_a = in_pc;
                w_b = w_immu;
            end
            default: w_ill = 1'b1;
        endcase
    end

    // A taken branch blocks intake for its own cycle and the redirect cycle.
    assign w_out_free = !r_out_valid || out_ready;
    assign w_ex_adv   = r_ex_valid && (r_ex_br || w_out_free);
    assign w_ex_taken = r_ex_valid && r_ex_br && alu_zero;
    assign in_ready   = (!r_ex_valid || w_ex_adv) && !w_ex_taken && !r_redir_valid;
    assign w_acc      = in_valid && in_ready;
    assign w_res      = r_ex_slt ? {31'b0, alu_zero} : alu_x;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid    <= 1'b0;
            r_ex_br       <= 1'b0;
            r_ex_slt      <= 1'b0;
            r_ex_rd       <= 5'b0;
            r_ex_tgt      <= 32'b0;
            r_alu_a       <= 32'b0;
            r_alu_b       <= 32'b0;
            r_alu_mode    <= M_ADD;
            r_out_valid   <= 1'b0;
            r_out_rd      <= 5'b0;
            r_out_data    <= 32'b0;
            r_redir_valid <= 1'b0;
            r_redir_pc    <= 32'b0;
            r_ill         <= 1'b0;
        end else begin
            r_ill         <= w_acc && w_ill;
            r_redir_valid <= w_ex_adv && w_ex_taken;
            if (w_ex_adv && w_ex_taken) begin
                r_redir_pc <= r_ex_tgt;
            end
            if (w_acc && !w_ill) begin
                r_ex_valid <= 1'b1;
                r_ex_br    <= w_br;
                r_ex_slt   <= w_slt;
                r_ex_rd    <= in_instr[11:7];
                r_ex_tgt   <= in_pc + w_immb;
                r_alu_a    <= w_a;
                r_alu_b    <= w_b;
                r_alu_mode <= w_mode;
            end else if (w_ex_adv) begin
                r_ex_valid <= 1'b0;
            end
            if (w_ex_adv && !r_ex_br) begin
                r_out_valid <= 1'b1;
                r_out_rd    <= r_ex_rd;
                r_out_data  <= w_res;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign alu_a          = r_alu_a;
    assign alu_b          = r_alu_b;
    assign alu_mode       = r_alu_mode;
    assign out_valid      = r_out_valid;
    assign out_rd         = r_out_rd;
    assign out_data       = r_out_data;
    assign redirect_valid = r_redir_valid;
    assign redirect_pc    = r_redir_pc;
    assign illegal        = r_ill;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU attached.
// Directed vectors push expected writeback entries; a monitor pops them.
module tb_alu_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_mode;
    logic [31:0] alu_x;
    logic        alu_zero;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        illegal;

    int n_vec = 0;
    int n_err = 0;
    logic [36:0] sb[$];

    always #5 clk = ~clk;

    alu_issue_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode),
        .alu_x(alu_x), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rd(out_rd), .out_data(out_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .illegal(illegal)
    );

    // Reference ALU: compare modes raise zero when the condition holds.
    always_comb begin
        alu_x = 32'b0;
        alu_zero = 1'b0;
        case (alu_mode)
            4'b0000: alu_x = alu_a + alu_b;
            4'b0001: alu_x = alu_a - alu_b;
            4'b0010: alu_x = alu_a & alu_b;
            4'b0011: alu_x = alu_a | alu_b;
            4'b0100: alu_x = alu_a ^ alu_b;
            4'b0101: alu_x = alu_a << alu_b[4:0];
            4'b0110: alu_x = alu_a >> alu_b[4:0];
            4'b0111: alu_x = $signed(alu_a) >>> alu_b[4:0];
            default: alu_x = 32'b0;
        endcase
        case (alu_mode)
            4'b1000: alu_zero = alu_a < alu_b;
            4'b1001: alu_zero = alu_a >= alu_b;
            4'b1011: alu_zero = alu_a != alu_b;
            4'b1100: alu_zero = $signed(alu_a) < $signed(alu_b);
            4'b1101: alu_zero = $signed(alu_a) >= $signed(alu_b);
            default: alu_zero = (alu_x == 32'b0);
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_out: got rd=%0d data=%h expected none",
                         out_rd, out_data);
            end else begin
                logic [36:0] e;
                e = sb.pop_front();
                chk("out_rd", {27'b0, out_rd}, {27'b0, e[36:32]});
                chk("out_data", out_data, e[31:0]);
            end
        end
    end

    function automatic logic [31:0] r_ins(input logic [6:0] f7,
                                          input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] b_ins(input logic [12:0] imm,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic send(input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] a, input logic [31:0] b,
                        input bit push, input logic [31:0] exp,
                        output int waits);
        bit acc;
        acc = 1'b0;
        waits = 0;
        in_valid = 1'b1;
        in_instr = ins;
        in_pc = pc;
        in_rs1 = a;
        in_rs2 = b;
        while (!acc && waits < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (!acc) waits++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got no accept expected accept");
        end else if (push) begin
            sb.push_back({ins[11:7], exp});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst = 1'b1;
        in_valid = 1'b0;
        in_instr = 32'b0;
        in_pc = 32'b0;
        in_rs1 = 32'b0;
        in_rs2 = 32'b0;
        out_ready = 1'b1;
        repeat (2) step();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_redirect", {31'b0, redirect_valid}, 32'd0);
        chk("rst_illegal", {31'b0, illegal}, 32'd0);
        chk("rst_mode", {28'b0, alu_mode}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        rst = 1'b0;
        step();

        // ADD wraps; latency two cycles to out_valid
        send(r_ins(7'h00, 3'b000, 5'd5), 32'h0, 32'hFFFF_FFFF, 32'd2, 1'b1, 32'h1, w);
        chk("add_mode", {28'b0, alu_mode}, 32'd0);
        chk("add_alu_a", alu_a, 32'hFFFF_FFFF);
        chk("add_lat1_valid", {31'b0, out_valid}, 32'd0);
        step();
        chk("add_lat2_valid", {31'b0, out_valid}, 32'd1);
        chk("add_lat2_rd", {27'b0, out_rd}, 32'd5);
        step();

        // Back-to-back with writeback stalled
        out_ready = 1'b0;
        send(r_ins(7'h20, 3'b000, 5'd6), 32'h0, 32'd10, 32'd3, 1'b1, 32'd7, w);
        chk("sub_waits", w, 32'd0);
        send(r_ins(7'h20, 3'b101, 5'd7), 32'h0, 32'h8000_0000, 32'd4, 1'b1,
             32'hF800_0000, w);
        chk("sra_waits", w, 32'd0);
        chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
        chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
        chk("stall_out_data", out_data, 32'd7);
        step();
        chk("stall2_in_ready", {31'b0, in_ready}, 32'd0);
        chk("stall2_out_data", out_data, 32'd7);
        out_ready = 1'b1;
        repeat (3) step();

        // Taken BEQ back 16 bytes
        send(b_ins(13'h1FF0, 3'b000), 32'h100, 32'd9, 32'd9, 1'b0, 32'd0, w);
        chk("beq_mode", {28'b0, alu_mode}, 32'b0001);
        chk("beq_in_ready", {31'b0, in_ready}, 32'd0);
        step();
        chk("beq_redirect", {31'b0, redirect_valid}, 32'd1);
        chk("beq_target", redirect_pc, 32'h0000_00F0);
        chk("beq_redir_in_ready", {31'b0, in_ready}, 32'd0);
        chk("beq_no_out", {31'b0, out_valid}, 32'd0);
        step();
        chk("beq_pulse_end", {31'b0, redirect_valid}, 32'd0);
        chk("beq_after_ready", {31'b0, in_ready}, 32'd1);

        // Not-taken BNE
        send(b_ins(13'h0020, 3'b001), 32'h200, 32'd5, 32'd5, 1'b0, 32'd0, w);
        chk("bne_mode", {28'b0, alu_mode}, 32'b1011);
        chk("bne_in_ready", {31'b0, in_ready}, 32'd1);
        send(r_ins(7'h00, 3'b000, 5'd8), 32'h0, 32'd3, 32'd4, 1'b1, 32'd7, w);
        chk("bne_next_waits", w, 32'd0);
        chk("bne_no_redirect", {31'b0, redirect_valid}, 32'd0);
        repeat (2) step();

        // Set-less-than unsigned vs signed
        send(r_ins(7'h00, 3'b011, 5'd9), 32'h0, 32'd1, 32'hFFFF_FFFF, 1'b1, 32'd1, w);
        send(r_ins(7'h00, 3'b010, 5'd10), 32'h0, 32'd1, 32'hFFFF_FFFF, 1'b1, 32'd0, w);
        repeat (3) step();

        // Load opcode is illegal
        send(32'h0000_2003, 32'h0, 32'd1, 32'd1, 1'b0, 32'd0, w);
        chk("ill_pulse", {31'b0, illegal}, 32'd1);
        step();
        chk("ill_pulse_end", {31'b0, illegal}, 32'd0);
        chk("ill_no_out", {31'b0, out_valid}, 32'd0);
        step();

        // Reset with entries in EX and OUT
        out_ready = 1'b0;
        send(r_ins(7'h20, 3'b000, 5'd11), 32'h0, 32'd5, 32'd1, 1'b0, 32'd0, w);
        send(r_ins(7'h20, 3'b000, 5'd12), 32'h0, 32'd9, 32'd1, 1'b0, 32'd0, w);
        chk("pre_rst_out_valid", {31'b0, out_valid}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_mode", {28'b0, alu_mode}, 32'd0);
        chk("flush_out_data", out_data, 32'd0);
        chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (4) step();
        chk("flush_no_out", {31'b0, out_valid}, 32'd0);
        chk("sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Execute-stage controller that drives the combinational ALU.
- It accepts a decoded RV32I instruction with its operand values, generates the ALU operands and 4-bit mode, and registers the ALU result toward writeback.
- It resolves branches from the ALU ZERO flag and issues a PC redirect.
- It sits between the register-read stage (valid/ready in) and the writeback stage (valid/ready out).

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction offered by upstream
- in_ready  out  1  controller accepts the offered instruction this cycle
- in_instr  in  32  raw RV32I instruction
- in_pc  in  32  instruction PC
- in_rs1  in  32  rs1 register value
- in_rs2  in  32  rs2 register value
- alu_a  out  32  ALU operand A, driven from the EX register
- alu_b  out  32  ALU operand B, driven from the EX register
- alu_mode  out  4  ALU mode, driven from the EX register
- alu_x  in  32  ALU result
- alu_zero  in  1  ALU ZERO flag
- out_valid  out  1  writeback entry valid
- out_ready  in  1  writeback stage accepts the entry
- out_rd  out  5  destination register
- out_data  out  32  result
- redirect_valid  out  1  one-cycle pulse: branch taken
- redirect_pc  out  32  branch target
- illegal  out  1  one-cycle pulse: unsupported instruction dropped

Behaviour:
- Reset values (applied on a rising edge with rst=1):
  - EX stage invalid; out_valid=0, redirect_valid=0, illegal=0.
  - alu_a, alu_b, out_data, redirect_pc = 0; alu_mode=4'b0000; out_rd=0.
  - An in-flight instruction in EX or OUT is discarded.
- Stages:
  - EX: registered instruction; alu_a, alu_b and alu_mode come from it.
  - OUT: registered result.
- ALU contract: for compare modes, alu_zero=1 exactly when the condition holds.
- Mode map (mode values are ALU 4-bit codes):
  - ADD/ADDI/AUIPC/LUI 0000; SUB 0001; AND 0010; OR 0011; XOR 0100.
  - SLL 0101; SRL 0110; SRA 0111.
  - SLTU/SLTIU/BLTU 1000; BGEU 1001; BNE 1011; SLT/SLTI/BLT 1100; BGE 1101; BEQ 0001.
- Operands:
  - OP: a=rs1, b=rs2.
  - OP-IMM: a=rs1, b=sign-extended I-immediate.
  - Shift amounts: b={27'b0, shamt[4:0]}.
  - LUI: a=0, b={imm[31:12], 12'b0}.
  - AUIPC: a=pc, same b as LUI.
  - BRANCH: a=rs1, b=rs2.
- Result:
  - SLT/SLTU/SLTI/SLTIU: result is {31'b0, alu_zero}.
  - All other ALU operations: result is alu_x; addition and subtraction wrap modulo 2^32.
- Handshake and occupancy:
  - ex_adv = EX valid AND (EX holds a branch OR OUT free), where OUT free = !out_valid OR out_ready.
  - in_ready = (!EX valid OR ex_adv) AND !(EX holds a taken branch) AND !redirect_valid.
  - Transfer occurs on in_valid AND in_ready.
  - OUT loads on ex_adv for non-branch instructions.
  - out_valid holds, and out_rd/out_data stay stable, until out_ready.
  - rd=x0 still produces an entry.
- Branch:
  - When EX holds a branch and ex_adv, taken = alu_zero.
  - If taken: the next cycle has redirect_valid=1 and redirect_pc = pc + sign-extended B-immediate (wraps mod 2^32).
  - Branches never write OUT.
  - The wrong-path instruction is never accepted during the branch cycle or the redirect cycle.
- Illegal:
  - Any opcode outside OP, OP-IMM, BRANCH, LUI, AUIPC is illegal; so are bad funct3/funct7 combinations.
  - The instruction is accepted, dropped at EX (illegal=1 for one cycle after acceptance), and produces no output.
- Throughput and latency:
  - One instruction per cycle with no backpressure.
  - Latency from accept to out_valid is 2 cycles.
  - With out_ready=0 and OUT full, EX holds and in_ready=0; nothing is lost or duplicated.

Test Plan:
1. Reset, then ADD rs1=0xFFFFFFFF rs2=2 rd=5 -> alu_mode=0000; 2 cycles later out_valid=1, out_rd=5, out_data=0x00000001.
2. Back-to-back SUB 10-3 then SRA 0x80000000 by 4, with out_ready=0 for 3 cycles -> in_ready=0 while stalled; entries 7 then 0xF8000000, in order, each exactly once.
3. BEQ rs1=rs2=9, pc=0x100, imm=-16 -> redirect_valid pulse with redirect_pc=0xF0; in_ready=0 in the branch and redirect cycles; no out_valid.
4. BNE with rs1=rs2 (alu_zero=0) -> no redirect, no output; the next instruction is accepted the following cycle.
5. SLTU 1 vs 0xFFFFFFFF -> out_data=1. SLT same operands -> out_data=0.
6. Opcode 0000011 -> illegal pulse, no output. Assert rst with entries in EX and OUT -> next cycle all valids=0 and alu_mode=0000.
